// File: rtl/simple_mmap_xform_pkg.sv
// simple_mmap_xform_pkg
// Shared definitions for the memory-mapped transform block: channel mode
// encodings, per-channel register offsets, and the STATUS word layout.
package simple_mmap_xform_pkg;

  typedef enum logic [1:0] {
    MODE_INVERT = 2'd0,
    MODE_PASS   = 2'd1,
    MODE_BSWAP  = 2'd2,
    MODE_ACCUM  = 2'd3
  } mode_e;

  // Word offsets inside a channel's 4-word register window
  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_MODE   = 2'd1;
  localparam logic [1:0] OFF_STATUS = 2'd2;
  localparam logic [1:0] OFF_RESULT = 2'd3;

  // STATUS layout: sticky overflow flag and saturating handshake count
  localparam int OVF_BIT  = 31;
  localparam int CNT_W    = 16;
  localparam int STATUS_W = 32;

endpackage

// File: rtl/simple_mmap_xform_ch.sv
// simple_mmap_xform_ch
// One transform channel: MODE register, accumulator, registered result with
// valid/ready output handshake, and STATUS (sticky OVF + handshake count).
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   ctrl_we_i        CTRL write strobe (data on wdata_i)
//   mode_we_i        MODE write strobe (data on wdata_i[1:0])
//   wdata_i          write data
//   status_rd_i      STATUS is being read this cycle (clears it next cycle)
//   out_ready_i      downstream ready
//   mode_o           current MODE
//   status_o         STATUS word
//   result_o         last computed result (RESULT register)
//   out_data_o       result towards downstream
//   out_valid_o      result valid
module simple_mmap_xform_ch
  import simple_mmap_xform_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              ctrl_we_i,
  input  logic              mode_we_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              status_rd_i,
  input  logic              out_ready_i,
  output logic [1:0]        mode_o,
  output logic [DATA_W-1:0] status_o,
  output logic [DATA_W-1:0] result_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_valid_o
);

  // STATUS is built 32 bits wide, then fitted to the data width
  localparam int SW = (DATA_W > STATUS_W) ? DATA_W : STATUS_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  mode_e             mode_q, mode_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              hs;
  logic              accept;
  logic              drop;
  logic [DATA_W-1:0] result;
  logic [SW-1:0]     status_w;

  function automatic logic [DATA_W-1:0] bswap(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int b = 0; b < DATA_W / 8; b++) begin
      r[b*8 +: 8] = d[DATA_W-8-b*8 +: 8];
    end
    return r;
  endfunction

  always_comb begin
    result = wdata_i;
    case (mode_q)
      MODE_INVERT: result = ~wdata_i;
      MODE_PASS:   result = wdata_i;
      MODE_BSWAP:  result = bswap(wdata_i);
      MODE_ACCUM:  result = acc_q + wdata_i;
      default:     result = wdata_i;
    endcase
  end

  assign hs     = valid_q & out_ready_i;
  // A held result blocks new CTRL writes unless it is leaving this cycle
  assign accept = ctrl_we_i & (~valid_q | out_ready_i);
  assign drop   = ctrl_we_i & valid_q & ~out_ready_i;

  always_comb begin
    mode_d  = mode_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (mode_we_i) begin
      mode_d = mode_e'(wdata_i[1:0]);
      acc_d  = '0;
    end

    if (accept) begin
      data_d  = result;
      valid_d = 1'b1;
      if (mode_q == MODE_ACCUM) begin
        acc_d = result;
      end
    end else if (hs) begin
      valid_d = 1'b0;
    end

    // Read-clear first, so events in the reading cycle land in the new epoch
    if (status_rd_i) begin
      ovf_d = 1'b0;
      cnt_d = '0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
    if (hs && (cnt_d != CNT_MAX)) begin
      cnt_d = cnt_d + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q  <= MODE_INVERT;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    status_w               = '0;
    status_w[CNT_W-1:0]    = cnt_q;
    status_w[OVF_BIT]      = ovf_q;
  end

  assign status_o    = status_w[DATA_W-1:0];
  assign mode_o      = mode_q;
  assign result_o    = data_q;
  assign out_data_o  = data_q;
  assign out_valid_o = valid_q;

endmodule

// File: rtl/simple_mmap_xform.sv
// simple_mmap_xform
// Register-mapped bank of NUM_CH transform channels. The top level decodes
// word addresses into per-channel strobes and returns reads through a
// registered mux (1-cycle latency). Channel c owns words c*4+0..c*4+3.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN  clock, asynchronous active-low reset
//   wr_en/wr_addr/wr_data      register write
//   rd_en/rd_addr              register read request
//   rd_data/rd_valid           read response, one cycle after rd_en
//   out_data/out_valid         per-channel results (channel c at c*DATA_W)
//   out_ready                  per-channel downstream ready
module simple_mmap_xform
  import simple_mmap_xform_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 5
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready
);

  localparam int IDX_W = ADDR_W - 2;

  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [1:0]        wr_off, rd_off;

  logic [1:0]        mode_a   [NUM_CH];
  logic [DATA_W-1:0] status_a [NUM_CH];
  logic [DATA_W-1:0] result_a [NUM_CH];

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q;

  assign wr_idx = wr_addr[ADDR_W-1:2];
  assign wr_off = wr_addr[1:0];
  assign rd_idx = rd_addr[ADDR_W-1:2];
  assign rd_off = rd_addr[1:0];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic wsel;
    logic ctrl_we;
    logic mode_we;
    logic status_rd;

    assign wsel      = wr_en && (wr_idx == IDX_W'(c));
    assign ctrl_we   = wsel && (wr_off == OFF_CTRL);
    assign mode_we   = wsel && (wr_off == OFF_MODE);
    assign status_rd = rd_en && (rd_idx == IDX_W'(c)) && (rd_off == OFF_STATUS);

    simple_mmap_xform_ch #(
      .DATA_W (DATA_W)
    ) u_ch (
      .clk_i       (S_AXI_ACLK),
      .rst_ni      (S_AXI_ARESETN),
      .ctrl_we_i   (ctrl_we),
      .mode_we_i   (mode_we),
      .wdata_i     (wr_data),
      .status_rd_i (status_rd),
      .out_ready_i (out_ready[c]),
      .mode_o      (mode_a[c]),
      .status_o    (status_a[c]),
      .result_o    (result_a[c]),
      .out_data_o  (out_data[c*DATA_W +: DATA_W]),
      .out_valid_o (out_valid[c])
    );
  end

  // Unmapped channel indices and CTRL fall through to zero
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_idx == IDX_W'(c)) begin
          case (rd_off)
            OFF_MODE:   rd_data_d = {{(DATA_W-2){1'b0}}, mode_a[c]};
            OFF_STATUS: rd_data_d = status_a[c];
            OFF_RESULT: rd_data_d = result_a[c];
            default:    rd_data_d = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule
